updown_counter: RTL

Parametrised up/down counter: the next generation of the team's 8-bit load/count block. Adds configurable width, a programmable terminal value (modulus), direction control, wrap or saturate mode, a tick prescaler, compare match and overflow reporting. The tri-state output is kept so the block can still drive a shared bus. It sits between the bus/IO pins and any control logic that needs programmable interval timing or event counting.

---
 rtl/updown_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with programmable terminal
// value, wrap/saturate boundary mode, tick prescaler, compare match, sticky
// overflow and a tri-state count output for driving a shared bus.
module updown_counter #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               count_en,
    input  logic               up_dn,
    input  logic               sat_mode,
    input  logic [WIDTH-1:0]   max_val,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic               clr_ovf,
    input  logic               oe,
    output logic [WIDTH-1:0]   count_out,
    output logic               tc,
    output logic               cmp_match,
    output logic               wrap,
    output logic               ovf
);

    localparam logic [WIDTH-1:0]   CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PCNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   cnt_q,  cnt_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               wrap_q, wrap_d;
    logic               ovf_q,  ovf_d;

    logic step;
    logic boundary;

    // Prescaler: decide whether this edge is a counting step and advance pcnt.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        step   = 1'b0;
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = '0;
        end else if (count_en) begin
            step   = (pcnt_q == presc);
            pcnt_d = step ? '0 : pcnt_q + PCNT_ONE;
        end
    end

    // Counter next value: load has priority, then a step, otherwise hold.
    always_comb begin
        boundary = 1'b0;
        cnt_d    = cnt_q;
        if (load) begin
            // Loaded values are clamped into the legal range 0..max_val.
            cnt_d = (data_in > max_val) ? max_val : data_in;
        end else if (step) begin
            if (up_dn) begin
                // >= rather than == so a lowered max_val still terminates.
                if (cnt_q >= max_val) begin
                    boundary = 1'b1;
                    cnt_d    = sat_mode ? max_val : '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                // Above max_val the count walks down unclamped.
                if (cnt_q == '0) begin
                    boundary = 1'b1;
                    cnt_d    = sat_mode ? '0 : max_val;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

    // Boundary reporting: one-cycle wrap pulse and sticky ovf (set beats clear).
    always_comb begin
        wrap_d = step && boundary;
        ovf_d  = (step && boundary) || (ovf_q && !clr_ovf);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pcnt_q <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Outputs: flags are decoded combinationally from the current count.
    always_comb begin
        tc        = up_dn ? (cnt_q >= max_val) : (cnt_q == '0);
        cmp_match = (cnt_q == cmp_val);
        wrap      = wrap_q;
        ovf       = ovf_q;
    end

    // Bus driver: release the shared bus when oe is low.
    assign count_out = oe ? cnt_q : {WIDTH{1'bz}};

endmodule
